// File: rtl/count_enable_pkg.sv
// Shared types and default sizes for the count-enable strobe generator.
package count_enable_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDivW  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/enable_prescaler.sv
// Divide-by-(div+1) counter; tick marks the cycle in which the count reaches div.
module enable_prescaler #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count_q, count_d;

  assign tick = run && !clear && (count_q == div);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/count_enable_gen.sv
// Strobe sequencer: issues burst_len (or unlimited) enable pulses every div+1 cycles
// for a downstream up-counter sharing clk.
module count_enable_gen
  import count_enable_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DIV_W = DefaultDivW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [WIDTH-1:0] burst_len,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] issued
);

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic [WIDTH-1:0] len_q;
  logic [WIDTH-1:0] issued_q;
  logic [WIDTH-1:0] issued_inc;
  logic             enable_q;
  logic             busy_q;
  logic             done_q;
  logic             accept;
  logic             run;
  logic             tick;
  logic             last;

  assign accept     = (state_q == StIdle) && start && !stop;
  assign run        = (state_q == StRun);
  assign issued_inc = issued_q + 1'b1;
  // len_q of zero selects continuous mode, so the burst never terminates on count.
  assign last       = (len_q != '0) && (issued_inc == len_q);

  enable_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .run  (run),
    .div  (div_q),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      div_q    <= '0;
      len_q    <= '0;
      issued_q <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q  <= StRun;
            div_q    <= div;
            len_q    <= burst_len;
            issued_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        StRun: begin
          // stop outranks a coincident strobe.
          if (stop) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (tick) begin
            enable_q <= 1'b1;
            issued_q <= issued_inc;
            if (last) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign enable = enable_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign issued = issued_q;

endmodule

// File: tb/tb_count_enable_gen.sv
// Bench for count_enable_gen: elapsed-cycle model checked every cycle plus literal traces.
module tb_count_enable_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] div = '0;
  logic [7:0] burst_len = '0;

  logic       en8, busy8, done8;
  logic [7:0] iss8;
  logic       en4, busy4, done4;
  logic [3:0] iss4;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  count_enable_gen u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .div      (div),
    .burst_len(burst_len),
    .enable   (en8),
    .busy     (busy8),
    .done     (done8),
    .issued   (iss8)
  );

  count_enable_gen #(
    .WIDTH(4)
  ) u_dut4 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .div      (div),
    .burst_len(burst_len[3:0]),
    .enable   (en4),
    .busy     (busy4),
    .done     (done4),
    .issued   (iss4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: strobes fall on every (div+1)-th edge after the accepting edge.
  bit m_run, m_pend, m_en, m_done;
  int m_k, m_per, m_n, m_iss;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_run = 0; m_pend = 0; m_en = 0; m_done = 0;
      m_k = 0; m_per = 1; m_n = 0; m_iss = 0;
    end else begin
      m_en = 0;
      m_done = 0;
      if (m_pend) begin
        m_pend = 0;
        m_done = 1;
      end else if (!m_run) begin
        if (start && !stop) begin
          m_run = 1; m_k = 0; m_per = int'(div) + 1; m_n = int'(burst_len); m_iss = 0;
        end
      end else if (stop) begin
        m_run = 0;
      end else begin
        m_k++;
        if (m_k % m_per == 0) begin
          m_en = 1;
          m_iss++;
          if (m_n != 0 && m_iss == m_n) begin
            m_run = 0;
            m_pend = 1;
          end
        end
      end
    end
  end

  bit chk_on = 0;
  int ds_cnt = 0;
  bit done_seen = 0;

  always @(negedge clk) begin
    if (reset && chk_on) begin
      chk("enable", en8, m_en);
      chk("busy", busy8, m_run);
      chk("done", done8, m_done);
      chk("issued", iss8, m_iss % 256);
      chk("enable w4", en4, m_en);
      chk("busy w4", busy4, m_run);
      chk("done w4", done4, m_done);
      chk("issued w4", iss4, m_iss % 16);
      if (en8) ds_cnt++;
      if (done8) done_seen = 1;
    end
  end

  task automatic start_seq(input int d, input int n);
    @(posedge clk); #2;
    start = 1; div = 8'(d); burst_len = 8'(n); ds_cnt = 0; done_seen = 0;
    @(posedge clk); #2;
    start = 0;
  endtask

  // Sample cycles c0..c(len-1) after the accepting edge against bit masks.
  task automatic trace(input string name, input logic [31:0] en_m, input logic [31:0] done_m,
                       input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      chk({name, " en"}, en8, en_m[i]);
      chk({name, " done"}, done8, done_m[i]);
    end
  endtask

  initial begin
    #12;
    chk("reset enable", en8, 0);
    chk("reset busy", busy8, 0);
    chk("reset done", done8, 0);
    chk("reset issued", iss8, 0);
    @(posedge clk); #2;
    reset = 1;
    chk_on = 1;

    // div=0, five back-to-back strobes then done
    start_seq(0, 5);
    trace("b5", 32'h0000_003E, 32'h0000_0040, 8);
    chk("b5 issued", iss8, 5);
    chk("b5 busy after", busy8, 0);

    // div=3, three strobes four cycles apart
    start_seq(3, 3);
    trace("d3", 32'h0000_1110, 32'h0000_2000, 16);
    #1;
    chk("d3 downstream count", ds_cnt, 3);
    chk("d3 issued", iss8, 3);

    // continuous div=1, stop sampled on edge 9
    start_seq(1, 0);
    repeat (8) @(posedge clk);
    #2 stop = 1;
    @(posedge clk); #2 stop = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("stop issued held", iss8, 4);
    chk("stop enables", ds_cnt, 4);
    chk("stop busy", busy8, 0);
    chk("stop no done", done_seen, 0);

    // stop on a strobe edge suppresses that strobe
    start_seq(1, 0);
    repeat (3) @(posedge clk);
    #2 stop = 1;
    @(posedge clk); #2 stop = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("stop-on-strobe issued", iss8, 1);
    chk("stop-on-strobe enables", ds_cnt, 1);

    // start with stop in idle is refused
    @(posedge clk); #2 start = 1; stop = 1;
    @(posedge clk); #2 start = 0; stop = 0;
    chk("start+stop busy", busy8, 0);
    chk("idle issued held", iss8, 1);

    // start during run with new div must not disturb the period
    start_seq(2, 4);
    start = 1; div = 8'd7; burst_len = 8'd9;
    trace("hold", 32'h0000_1248, 32'h0000_2000, 14);
    start = 0;
    chk("hold issued", iss8, 4);

    // asynchronous reset mid-burst
    start_seq(0, 10);
    repeat (3) @(posedge clk);
    #3 reset = 0;
    #1;
    chk("async rst enable", en8, 0);
    chk("async rst busy", busy8, 0);
    chk("async rst issued", iss8, 0);
    chk("async rst done", done8, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1;
    start_seq(0, 2);
    trace("restart", 32'h0000_0006, 32'h0000_0008, 5);
    chk("restart issued", iss8, 2);

    // continuous div=0 for 20 strobes; 4-bit issued wraps
    start_seq(0, 0);
    repeat (20) @(posedge clk);
    #2;
    chk("wrap issued w4", iss4, 4);
    chk("wrap issued w8", iss8, 20);
    chk("wrap enable w4", en4, 1);
    stop = 1;
    @(posedge clk); #2 stop = 0;
    repeat (2) @(posedge clk);

    @(negedge clk);
    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/count_enable_gen.md
COUNT_ENABLE_GEN -- requirements
Module: count_enable_gen

Interface
REQ-001 Parameter WIDTH, default 8, width of burst length and issued-strobe count.
REQ-002 Parameter DIV_W, default 8, width of the divide ratio.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a strobe sequence; sampled only in IDLE.
REQ-006 stop  input  1  abort request; sampled in IDLE and RUN.
REQ-007 div  input  DIV_W  strobe period minus one; captured on accepted start.
REQ-008 burst_len  input  WIDTH  strobes to issue; 0 means continuous; captured on accepted start.
REQ-009 enable  output  1  registered one-cycle strobe driving the downstream up-counter enable.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  registered one-cycle pulse when a burst completes normally.
REQ-012 issued  output  WIDTH  number of strobes issued in the current or last sequence.

Function
REQ-013 FSM states IDLE, RUN, DONE; encoding is not visible at the ports.
REQ-014 IDLE -> RUN on an edge with start=1 and stop=0; div and burst_len are captured, the prescaler is cleared to 0, and issued is cleared to 0.
REQ-015 IDLE with start=1 and stop=1 stays in IDLE; stop wins.
REQ-016 In RUN, the prescaler increments each cycle and wraps to 0 after reaching captured div; enable is high for the cycle following the wrap edge.
REQ-017 Strobe period is div+1 cycles; div=0 gives enable high every cycle in RUN.
REQ-018 Latency: start is accepted at edge E0; the first enable is high after edge E0+div+1.
REQ-019 Each enable high cycle increments issued by 1, modulo 2^WIDTH; wrap is legal in continuous mode only.
REQ-020 With burst_len=N>0, the edge that issues strobe N moves RUN -> DONE; exactly N enables are issued.
REQ-021 DONE lasts one cycle: done=1, enable=0, busy=0, then IDLE.
REQ-022 stop=1 sampled in RUN moves to IDLE on that edge.
REQ-023 On stop, no enable is produced from that edge, done is not asserted, and issued holds its value.
REQ-024 stop coinciding with the edge that would issue a strobe suppresses that strobe; stop wins.
REQ-025 start while busy or in DONE is ignored; captured div and burst_len do not change mid-sequence.
REQ-026 issued holds its value in IDLE until the next accepted start.
REQ-027 In IDLE: enable=0 and busy=0.

Reset
REQ-028 reset=0 asynchronously forces IDLE, prescaler=0, enable=0, busy=0, done=0, issued=0, and captured registers to 0, regardless of clk.
REQ-029 Reset asserted mid-RUN aborts immediately: no further enable, no done pulse.
REQ-030 After reset deassertion, the block waits in IDLE for start; the first accepted start follows REQ-014.

Structure
REQ-031 Package count_enable_pkg holds the state enum typedef and the default WIDTH/DIV_W constants.
REQ-032 One sub-module enable_prescaler (ports clk, reset, clear, run, div, tick) implements the divide-by-(div+1) counter.
REQ-033 The top level holds the FSM, capture registers, and issued counter.
REQ-034 enable is a direct registered function of tick and state.
REQ-035 Output enable connects directly to the existing sync_up_counter enable, sharing clk.

Verification
REQ-036 Reset then start with div=0, burst_len=5 -> enable high 5 consecutive cycles, issued=5, done pulse one cycle later, busy low after.
REQ-037 div=3, burst_len=3 -> enables 4 cycles apart starting 4 cycles after start, issued=1,2,3; downstream counter reads 3.
REQ-038 div=1, burst_len=0, stop after 9 cycles -> 4 enables, no done, issued=4 held in IDLE.
REQ-039 start and stop together in IDLE -> stays IDLE, busy=0; start during RUN with new div=7 -> period unchanged.
REQ-040 reset driven low mid-burst between clock edges -> outputs zero immediately; after release and a new start, sequence restarts with issued=0.
REQ-041 Continuous mode, WIDTH=4, div=0, 20 cycles -> issued wraps 15 -> 0, enable stays periodic.
